game_round_ctrl: RTL and testbench
==================================

# game_round_ctrl

Round sequencer for the 0.1 s game clock counter. It turns the start and pause push-buttons into a round flow: idle, clear, ready countdown, run, pause, time-up. It drives the game clock's enable, clear and speed-select inputs, and reads back its 10-bit tenths count to schedule speed levels and end the round. It sits between the board keys and the game clock, replacing direct SWITCH wiring.

## Interface
- TICK_DIV, 1000000: CLOCK10M cycles per 0.1 s countdown tick.
- COUNTDOWN_SEC, 3: ready countdown length in seconds (1..3).
- LEVEL_STEP, 200: tenths per speed level (20.0 s).
- TIME_LIMIT, 600: tenths at which the round ends (≤1023).

- CLOCK10M  in  1  10 MHz system clock.
- KEY0  in  1  reset; synchronous, active-high.
- KEY_START  in  1  start button, active-high level, asynchronous to clock.
- KEY_PAUSE  in  1  pause button, active-high level, asynchronous to clock.
- counter_in  in  10  game clock tenths count.
- clk_run  out  1  game clock enable (its SWITCH[0]).
- clk_clear  out  1  game clock clear (its KEY0).
- clk_speed  out  2  game clock speed select (its SWITCH[2:1]); count rate ×2^clk_speed.
- state  out  3  IDLE=0, CLEAR=1, READY=2, RUN=3, PAUSE=4, TIMEUP=5.
- countdown  out  2  ready digit 3/2/1; 0 outside READY.
- time_up  out  1  high in TIMEUP.
- level  out  2  current speed level, equal to clk_speed.

## Operation
- Each key passes through a 2-FF synchronizer followed by a rising-edge detector (sync & ~prev). Only edges act; held keys do nothing further.
- IDLE: clk_run=0, clk_clear=0. Start edge -> CLEAR.
- CLEAR: exactly 2 cycles with clk_run=1 and clk_clear=1. Both cycles are needed because the game clock clears only while enabled, and the second cycle guarantees a clean 0. level/clk_speed are set to 0 and the prescaler is zeroed. Then go to READY.
- READY: clk_run=0. Prescaler counts 0..TICK_DIV-1; a tick counter counts tenths up to 10·COUNTDOWN_SEC.
  - countdown = COUNTDOWN_SEC − (ticks/10). Use comparisons, not a divider.
  - On the final tick -> RUN.
  - Start and pause edges are ignored.
- RUN: clk_run=1.
  - counter_in ≥ TIME_LIMIT -> TIMEUP. This has priority over a same-cycle pause edge.
  - Otherwise a pause edge -> PAUSE.
  - Start edge is ignored.
  - level = 3 if counter_in ≥ 3·LEVEL_STEP, 2 if ≥ 2·LEVEL_STEP, 1 if ≥ LEVEL_STEP, else 0. Use 12-bit compares, no divider.
- PAUSE: clk_run=0; level holds. Pause edge -> RUN. Start edge -> CLEAR (restart). If both edges arrive in the same cycle, start wins.
- TIMEUP: clk_run=0, time_up=1, level holds. Start edge -> CLEAR. Pause edge is ignored.
- The controller never modifies counter_in. The count freezes whenever clk_run=0.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, clk_run=0, clk_clear=0, clk_speed=0, level=0, countdown=0, time_up=0.
  - Prescaler, tick counter and all synchronizer/edge flops are 0.
- Key latency: state updates on the 3rd rising edge after the first edge that samples the key high. A key held high through reset release counts as one edge.
- CLEAR lasts exactly 2 cycles. READY lasts exactly 10·COUNTDOWN_SEC·TICK_DIV cycles.
- clk_speed/level update 1 cycle after counter_in crosses a threshold; they saturate at 3.
- TIMEUP is entered 1 cycle after counter_in ≥ TIME_LIMIT is first sampled in RUN. With TIME_LIMIT=0, TIMEUP follows the first RUN cycle.
- KEY0 at any time returns to IDLE with reset values on the next edge. The countdown restarts from full on the next start.

## Test plan
Benches use TICK_DIV=4, COUNTDOWN_SEC=1, LEVEL_STEP=5, TIME_LIMIT=20.
- Reset, then a 1-cycle KEY_START pulse -> state=CLEAR on the 3rd edge; clk_run=clk_clear=1 for exactly 2 cycles; then state=READY, countdown=1.
- READY -> countdown=1 for exactly 40 cycles, then state=RUN, clk_run=1, countdown=0. A pause pulse during READY has no effect.
- RUN, counter_in driven 0,4,5,10,15,19 -> clk_speed 0,0,1,2,3,3, each one cycle after the change.
- RUN, counter_in=20 in the same cycle a pause edge is detected -> state=TIMEUP, time_up=1, clk_run=0. A start edge then gives CLEAR, level=0.
- RUN, pause edge -> PAUSE, clk_run=0. Second pause edge -> RUN. Pause edge, then start edge -> CLEAR.
- KEY0 asserted at cycle 20 of READY -> IDLE with all outputs at reset values next edge. A new start gives a full 40-cycle READY.

Source files
------------

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl
// Brief    : Round sequencer for the 0.1 s game clock: idle, clear, ready
//            countdown, run, pause and time-up, driven by start/pause keys.
// Revision : 1.0 - initial release
// ============================================================================
module game_round_ctrl #(
    parameter int TICK_DIV      = 1000000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int LEVEL_STEP    = 200,
    parameter int TIME_LIMIT    = 600
) (
    input  logic       CLOCK10M,
    input  logic       KEY0,
    input  logic       KEY_START,
    input  logic       KEY_PAUSE,
    input  logic [9:0] counter_in,
    output logic       clk_run,
    output logic       clk_clear,
    output logic [1:0] clk_speed,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic       time_up,
    output logic [1:0] level
);

    localparam int                   C_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(TICK_DIV - 1);
    localparam logic [4:0]           C_TICK_LAST  = 5'(10 * COUNTDOWN_SEC - 1);
    localparam logic [1:0]           C_CD_FULL    = 2'(COUNTDOWN_SEC);
    localparam logic [11:0]          C_LVL1       = 12'(LEVEL_STEP);
    localparam logic [11:0]          C_LVL2       = 12'(2 * LEVEL_STEP);
    localparam logic [11:0]          C_LVL3       = 12'(3 * LEVEL_STEP);
    localparam logic [11:0]          C_LIMIT      = 12'(TIME_LIMIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_TIMEUP = 3'd5;

    logic                 r_start_s1, r_start_s2, r_start_prev;
    logic                 r_pause_s1, r_pause_s2, r_pause_prev;
    logic [2:0]           r_state;
    logic                 r_run;
    logic                 r_clear;
    logic [1:0]           r_level;
    logic [1:0]           r_countdown;
    logic                 r_time_up;
    logic                 r_clear_cnt;
    logic [C_PRESC_W-1:0] r_presc;
    logic [4:0]           r_ticks;

    logic                 w_start_edge;
    logic                 w_pause_edge;
    logic [11:0]          w_count_ext;
    logic                 w_time_hit;
    logic [1:0]           w_level_next;
    logic [4:0]           w_ticks_inc;
    logic [1:0]           w_cd_next;

    assign w_start_edge = r_start_s2 & ~r_start_prev;
    assign w_pause_edge = r_pause_s2 & ~r_pause_prev;
    assign w_count_ext  = {2'b00, counter_in};
    assign w_time_hit   = (w_count_ext >= C_LIMIT);
    assign w_ticks_inc  = r_ticks + 5'd1;
    // Countdown digit from whole seconds elapsed, without a divider
    assign w_cd_next    = C_CD_FULL - {1'b0, (w_ticks_inc >= 5'd10)}
                                    - {1'b0, (w_ticks_inc >= 5'd20)};

    always_comb begin
        w_level_next = 2'd0;
        if (w_count_ext >= C_LVL3)
            w_level_next = 2'd3;
        else if (w_count_ext >= C_LVL2)
            w_level_next = 2'd2;
        else if (w_count_ext >= C_LVL1)
            w_level_next = 2'd1;
    end

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            r_start_s1   <= 1'b0;
            r_start_s2   <= 1'b0;
            r_start_prev <= 1'b0;
            r_pause_s1   <= 1'b0;
            r_pause_s2   <= 1'b0;
            r_pause_prev <= 1'b0;
            r_state      <= S_IDLE;
            r_run        <= 1'b0;
            r_clear      <= 1'b0;
            r_level      <= 2'd0;
            r_countdown  <= 2'd0;
            r_time_up    <= 1'b0;
            r_clear_cnt  <= 1'b0;
            r_presc      <= '0;
            r_ticks      <= 5'd0;
        end else begin
            r_start_s1   <= KEY_START;
            r_start_s2   <= r_start_s1;
            r_start_prev <= r_start_s2;
            r_pause_s1   <= KEY_PAUSE;
            r_pause_s2   <= r_pause_s1;
            r_pause_prev <= r_pause_s2;

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state     <= S_CLEAR;
                        r_run       <= 1'b1;
                        r_clear     <= 1'b1;
                        r_level     <= 2'd0;
                        r_presc     <= '0;
                        r_ticks     <= 5'd0;
                        r_clear_cnt <= 1'b0;
                    end
                end
                // Game clock clears only while enabled; hold both for two cycles
                S_CLEAR: begin
                    if (r_clear_cnt) begin
                        r_state     <= S_READY;
                        r_run       <= 1'b0;
                        r_clear     <= 1'b0;
                        r_countdown <= C_CD_FULL;
                        r_presc     <= '0;
                        r_ticks     <= 5'd0;
                    end else begin
                        r_clear_cnt <= 1'b1;
                    end
                end
                S_READY: begin
                    if (r_presc == C_PRESC_LAST) begin
                        r_presc <= '0;
                        if (r_ticks == C_TICK_LAST) begin
                            r_state     <= S_RUN;
                            r_run       <= 1'b1;
                            r_countdown <= 2'd0;
                        end else begin
                            r_ticks     <= w_ticks_inc;
                            r_countdown <= w_cd_next;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_RUN: begin
                    r_level <= w_level_next;
                    if (w_time_hit) begin
                        r_state   <= S_TIMEUP;
                        r_run     <= 1'b0;
                        r_time_up <= 1'b1;
                    end else if (w_pause_edge) begin
                        r_state <= S_PAUSE;
                        r_run   <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_start_edge) begin
                        r_state     <= S_CLEAR;
                        r_run       <= 1'b1;
                        r_clear     <= 1'b1;
                        r_level     <= 2'd0;
                        r_presc     <= '0;
                        r_ticks     <= 5'd0;
                        r_clear_cnt <= 1'b0;
                    end else if (w_pause_edge) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end
                end
                S_TIMEUP: begin
                    if (w_start_edge) begin
                        r_state     <= S_CLEAR;
                        r_run       <= 1'b1;
                        r_clear     <= 1'b1;
                        r_time_up   <= 1'b0;
                        r_level     <= 2'd0;
                        r_presc     <= '0;
                        r_ticks     <= 5'd0;
                        r_clear_cnt <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_run       <= 1'b0;
                    r_clear     <= 1'b0;
                    r_level     <= 2'd0;
                    r_countdown <= 2'd0;
                    r_time_up   <= 1'b0;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign clk_run   = r_run;
    assign clk_clear = r_clear;
    assign clk_speed = r_level;
    assign level     = r_level;
    assign countdown = r_countdown;
    assign time_up   = r_time_up;

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_round_ctrl
// Brief    : Directed bench for game_round_ctrl with a cycle-level round model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_round_ctrl;

    localparam int TD        = 4;
    localparam int CS        = 1;
    localparam int LS        = 5;
    localparam int TL        = 20;
    localparam int READY_CYC = 10 * CS * TD;

    logic       CLOCK10M   = 1'b0;
    logic       KEY0       = 1'b1;
    logic       KEY_START  = 1'b0;
    logic       KEY_PAUSE  = 1'b0;
    logic [9:0] counter_in = 10'd0;
    logic       clk_run;
    logic       clk_clear;
    logic [1:0] clk_speed;
    logic [2:0] state;
    logic [1:0] countdown;
    logic       time_up;
    logic [1:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    game_round_ctrl #(
        .TICK_DIV      (TD),
        .COUNTDOWN_SEC (CS),
        .LEVEL_STEP    (LS),
        .TIME_LIMIT    (TL)
    ) u_dut (
        .CLOCK10M   (CLOCK10M),
        .KEY0       (KEY0),
        .KEY_START  (KEY_START),
        .KEY_PAUSE  (KEY_PAUSE),
        .counter_in (counter_in),
        .clk_run    (clk_run),
        .clk_clear  (clk_clear),
        .clk_speed  (clk_speed),
        .state      (state),
        .countdown  (countdown),
        .time_up    (time_up),
        .level      (level)
    );

    always #50 CLOCK10M = ~CLOCK10M;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lvl_of(input int c);
        return (c / LS > 3) ? 3 : c / LS;
    endfunction

    // Round model: phase plus cycles spent in it; key history sampled per edge
    int         m_state = 0;
    int         m_el    = 0;
    int         m_level = 0;
    logic [2:0] hs      = 3'b000;
    logic [2:0] hp      = 3'b000;
    wire        m_se    = hs[1] & ~hs[2];
    wire        m_pe    = hp[1] & ~hp[2];

    always @(posedge CLOCK10M) begin
        if (KEY0) begin
            m_state <= 0;
            m_el    <= 0;
            m_level <= 0;
            hs      <= 3'b000;
            hp      <= 3'b000;
        end else begin
            hs <= {hs[1:0], KEY_START};
            hp <= {hp[1:0], KEY_PAUSE};
            case (m_state)
                0: if (m_se) begin m_state <= 1; m_el <= 0; m_level <= 0; end
                1: if (m_el == 1) begin m_state <= 2; m_el <= 0; end
                   else m_el <= m_el + 1;
                2: if (m_el == READY_CYC - 1) begin m_state <= 3; m_el <= 0; end
                   else m_el <= m_el + 1;
                3: begin
                    m_level <= lvl_of(int'(counter_in));
                    if (int'(counter_in) >= TL) m_state <= 5;
                    else if (m_pe)              m_state <= 4;
                end
                4: if (m_se) begin m_state <= 1; m_el <= 0; m_level <= 0; end
                   else if (m_pe) m_state <= 3;
                5: if (m_se) begin m_state <= 1; m_el <= 0; m_level <= 0; end
                default: m_state <= 0;
            endcase
        end
    end

    always @(negedge CLOCK10M) begin
        check("model_state",     int'(state),     m_state);
        check("model_clk_run",   int'(clk_run),   (m_state == 1 || m_state == 3) ? 1 : 0);
        check("model_clk_clear", int'(clk_clear), (m_state == 1) ? 1 : 0);
        check("model_clk_speed", int'(clk_speed), m_level);
        check("model_level",     int'(level),     m_level);
        check("model_countdown", int'(countdown), (m_state == 2) ? CS - m_el / (10 * TD) : 0);
        check("model_time_up",   int'(time_up),   (m_state == 5) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK10M);
    endtask

    task automatic pulse_start;
        KEY_START = 1'b1;
        tick(1);
        KEY_START = 1'b0;
    endtask

    task automatic pulse_pause;
        KEY_PAUSE = 1'b1;
        tick(1);
        KEY_PAUSE = 1'b0;
    endtask

    int sp_in  [6] = '{0, 4, 5, 10, 15, 19};
    int sp_exp [6] = '{0, 0, 1, 2, 3, 3};

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_state", int'(state), 0);
        check("rst_run",   int'(clk_run), 0);
        check("rst_clear", int'(clk_clear), 0);
        check("rst_speed", int'(clk_speed), 0);
        check("rst_cd",    int'(countdown), 0);
        check("rst_tu",    int'(time_up), 0);
        KEY0 = 1'b0;
        tick(2);

        // Start pulse: CLEAR on the 3rd edge, two CLEAR cycles, then READY
        pulse_start;
        check("start_lat1", int'(state), 0);
        tick(1);
        check("start_lat2", int'(state), 0);
        tick(1);
        check("clear1_state", int'(state), 1);
        check("clear1_run",   int'(clk_run), 1);
        check("clear1_clr",   int'(clk_clear), 1);
        tick(1);
        check("clear2_clr", int'(clk_clear), 1);
        tick(1);
        check("ready_state", int'(state), 2);
        check("ready_cd",    int'(countdown), 1);
        check("ready_run",   int'(clk_run), 0);
        tick(5);
        pulse_pause;
        tick(33);
        check("ready_last", int'(state), 2);
        tick(1);
        check("run_state", int'(state), 3);
        check("run_run",   int'(clk_run), 1);
        check("run_cd",    int'(countdown), 0);

        for (int i = 0; i < 6; i++) begin
            counter_in = 10'(sp_in[i]);
            tick(1);
            check($sformatf("speed_at_%0d", sp_in[i]), int'(clk_speed), sp_exp[i]);
        end

        // Pause / resume / restart
        pulse_pause;
        tick(2);
        check("pause_state", int'(state), 4);
        check("pause_run",   int'(clk_run), 0);
        check("pause_level", int'(level), 3);
        tick(2);
        pulse_pause;
        tick(2);
        check("resume_state", int'(state), 3);
        tick(2);
        pulse_pause;
        tick(2);
        check("pause2_state", int'(state), 4);
        tick(2);
        pulse_start;
        tick(2);
        check("restart_state", int'(state), 1);
        check("restart_level", int'(level), 0);
        counter_in = 10'd0;
        tick(42);
        check("run2_state", int'(state), 3);
        counter_in = 10'd19;
        tick(3);

        // Limit reached in the same cycle as a pause edge: time-up wins
        pulse_pause;
        tick(1);
        counter_in = 10'd20;
        tick(1);
        check("timeup_state", int'(state), 5);
        check("timeup_flag",  int'(time_up), 1);
        check("timeup_run",   int'(clk_run), 0);
        tick(2);
        pulse_start;
        tick(2);
        check("tu_restart_state", int'(state), 1);
        check("tu_restart_level", int'(level), 0);
        check("tu_restart_flag",  int'(time_up), 0);
        counter_in = 10'd0;

        // Reset in the middle of READY, then a full countdown again
        tick(21);
        check("mid_ready_state", int'(state), 2);
        KEY0 = 1'b1;
        tick(1);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_run",   int'(clk_run), 0);
        check("mid_rst_cd",    int'(countdown), 0);
        KEY0 = 1'b0;
        tick(2);
        pulse_start;
        tick(43);
        check("ready_full_last", int'(state), 2);
        tick(1);
        check("ready_full_run", int'(state), 3);

        // Start held through reset release counts as one edge
        KEY0      = 1'b1;
        KEY_START = 1'b1;
        tick(3);
        KEY0 = 1'b0;
        tick(3);
        check("held_start_state", int'(state), 1);
        tick(8);
        check("held_no_retrigger", int'(state), 2);
        KEY_START = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
